ramscan: RTL
============

Name: ramscan

Overview:
- Read-side counterpart of the ADC capture-RAM filler.
- Runs entirely in the VGA pixel clock domain.
- Arms a capture, waits for the capture-finished pulse, then reads the 2048-word sample RAM column by column in step with the VGA scan and outputs a 1-bit waveform pixel.
- Holds each captured frame for a programmable number of video frames, then re-arms.

Parameters:
H_ACTIVE, 640, visible columns; columns >= H_ACTIVE are never read
DECIM, 3, RAM words skipped per screen column (downsampling ratio)
SKIP, 16, base RAM address; excludes words overwritten while capture_enable deasserts across clock domains
Y_OFFSET, 112, screen row of sample code 255 (top of trace window)
HOLD_FRAMES, 30, video frames a capture is displayed before re-arming (1..255)

Ports:
clk  in  1  VGA pixel clock
reset  in  1  asynchronous, active-low
r_finished  in  1  one-clk pulse, already synchronised to clk, capture RAM full
CounterX  in  10  current scan column from the sync generator
CounterY  in  10  current scan row from the sync generator
inDisplayArea  in  1  scan position is visible
ram_q  in  14  RAM read data; synchronous read, valid 1 clk after rd_addr/rd_en
capture_enable  out  1  drives the filler's enable
rd_addr  out  11  RAM read address
rd_en  out  1  RAM read strobe
pixel_on  out  1  waveform pixel, 3 clk after the CounterX/CounterY it belongs to
state  out  2  IDLE=0, ARM=1, WAIT_FRAME=2, DISPLAY=3

Behaviour:
- Reset (reset low, async): state=IDLE; capture_enable, rd_en, pixel_on = 0; rd_addr=0; hold counter=0; all pipeline registers cleared.
- frame_start = (CounterX==0 && CounterY==0), sampled at the input stage.
- FSM transitions:
  - IDLE -> ARM on first frame_start.
  - ARM: capture_enable=1. On r_finished, capture_enable is 0 from the next clk and the FSM goes to WAIT_FRAME. This holds even if frame_start coincides.
  - WAIT_FRAME -> DISPLAY on the next frame_start; hold counter loads HOLD_FRAMES.
  - DISPLAY: each later frame_start decrements the hold counter. When a frame_start arrives with the counter at 1, the FSM goes to ARM.
  - r_finished outside ARM is ignored.
- Transitions take effect only at frame boundaries, so there is never a partial frame of new data.
- Read pipeline:
  - Stage 1 (registered, cycle t+1):
    - rd_en = (state==DISPLAY) && inDisplayArea && CounterX < H_ACTIVE.
    - rd_addr = SKIP + CounterX*DECIM, computed at 12 bits and truncated to 11 bits.
    - If the 12-bit result > 2047, rd_en=0.
    - When rd_en=0, rd_addr holds its previous value.
  - Stage 2 (t+2):
    - ram_q is valid.
    - row = Y_OFFSET + (255 - ram_q[13:6]), 10-bit. The top 8 bits of ram_q are inverted so that high voltage is drawn at the top.
    - CounterY and the stage-1 rd_en arrive through matching delay registers.
  - Stage 3 (t+3): pixel_on = delayed rd_en && (delayed CounterY == row).
- ARM, IDLE and WAIT_FRAME show a blank trace (pixel_on=0). The RAM is never read while the filler may write.
- Reset asserted mid-frame: outputs clear immediately. After release, the FSM restarts at IDLE and waits for a full frame.

Optional Feature:
Macro TRACE_FILL_EN.
- Defined:
  - Stage 2 keeps a register prev_row holding the row of the previous visible column.
  - pixel_on = 1 when delayed CounterY is within [min(prev_row,row), max(prev_row,row)] inclusive, giving a connected trace.
  - At column 0 (first read of each scan line), prev_row is loaded with the current row, so there is no vertical line from the previous line's end.
- Not defined: equality compare only, as above.

Test Plan:
- Reset low mid-DISPLAY -> same clk: capture_enable=0, rd_en=0, pixel_on=0, state=IDLE. After release, ARM entered on the next CounterX=0/CounterY=0 only.
- ARM, pulse r_finished at an arbitrary scan point -> capture_enable=0 next clk, state=WAIT_FRAME; DISPLAY from the next frame_start; pixel_on=0 until then.
- DISPLAY, CounterX=100 -> rd_addr=316, rd_en=1 one clk later. CounterX=639 -> rd_addr=1933. CounterX=700 or inDisplayArea=0 -> rd_en=0.
- ram_q=14'h3FC0 (code 255) at column 10 -> pixel_on=1 exactly at row 112, 3 clk after CounterX=10. ram_q=0 -> pixel_on only at row 367.
- HOLD_FRAMES=2: count frame_starts -> exactly 2 frames shown, then state=ARM and capture_enable=1 at the 3rd frame_start after DISPLAY entry.
- TRACE_FILL_EN, column 4 row 150, column 5 row 160 -> column 5 pixel_on for rows 150..160 (11 rows). Without the macro -> row 160 only.

Source files
------------

// File: rtl/ramscan.sv
`default_nettype none
// ============================================================================
// Module   : ramscan
// Purpose  : Read side of the ADC capture RAM. Arms a capture, waits for the
//            filler to report a full RAM, then displays the 2048-word sample
//            buffer as a 1-bit waveform trace. The RAM is read one screen
//            column at a time, in step with the VGA scan. Each captured frame
//            is held on screen for HOLD_FRAMES video frames before re-arming.
//            Everything runs in the VGA pixel clock domain.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk            in   1   VGA pixel clock
//   reset          in   1   asynchronous reset, active low
//   r_finished     in   1   one-clk pulse (already in clk domain): RAM full
//   CounterX       in  10   current scan column
//   CounterY       in  10   current scan row
//   inDisplayArea  in   1   scan position is visible
//   ram_q          in  14   RAM read data, valid 1 clk after rd_addr/rd_en
//   capture_enable out  1   enable for the capture-RAM filler
//   rd_addr        out 11   RAM read address
//   rd_en          out  1   RAM read strobe
//   pixel_on       out  1   waveform pixel, 3 clk after its CounterX/CounterY
//   state          out  2   IDLE=0, ARM=1, WAIT_FRAME=2, DISPLAY=3
// ----------------------------------------------------------------------------
// Optional build macro:
//   TRACE_FILL_EN  when defined, each column draws a vertical run between the
//                  previous column's sample row and its own, which gives a
//                  connected trace. When undefined, only the exact sample row
//                  is lit.
// ============================================================================
module ramscan #(
  parameter int H_ACTIVE    = 640,  // visible columns
  parameter int DECIM       = 3,    // RAM words per screen column
  parameter int SKIP        = 16,   // first displayed RAM address
  parameter int Y_OFFSET    = 112,  // screen row of sample code 255
  parameter int HOLD_FRAMES = 30    // video frames per capture (1..255)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r_finished,
  input  logic [9:0]  CounterX,
  input  logic [9:0]  CounterY,
  input  logic        inDisplayArea,
  input  logic [13:0] ram_q,
  output logic        capture_enable,
  output logic [10:0] rd_addr,
  output logic        rd_en,
  output logic        pixel_on,
  output logic [1:0]  state
);

  localparam logic [1:0]  c_IDLE       = 2'd0;
  localparam logic [1:0]  c_ARM        = 2'd1;
  localparam logic [1:0]  c_WAIT_FRAME = 2'd2;
  localparam logic [1:0]  c_DISPLAY    = 2'd3;

  localparam logic [10:0] c_H_ACTIVE   = 11'(H_ACTIVE);
  localparam logic [11:0] c_SKIP       = 12'(SKIP);
  localparam logic [11:0] c_DECIM      = 12'(DECIM);
  localparam logic [9:0]  c_Y_OFFSET   = 10'(Y_OFFSET);
  localparam logic [7:0]  c_HOLD       = 8'(HOLD_FRAMES);

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [7:0] r_hold;
  logic [7:0] w_hold_nxt;
  logic       w_frame_start;

  assign w_frame_start = (CounterX == 10'd0) && (CounterY == 10'd0);

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    case (r_state)
      c_IDLE: begin
        if (w_frame_start) w_state_nxt = c_ARM;
      end
      c_ARM: begin
        // Capture completion wins over a coincident frame start: the new data
        // is first shown at the frame start that follows.
        if (r_finished) w_state_nxt = c_WAIT_FRAME;
      end
      c_WAIT_FRAME: begin
        if (w_frame_start) begin
          w_state_nxt = c_DISPLAY;
          w_hold_nxt  = c_HOLD;
        end
      end
      c_DISPLAY: begin
        if (w_frame_start) begin
          // A counter of 0 can only come from an out-of-range HOLD_FRAMES.
          // It is treated like 1 so the FSM never stays in DISPLAY forever.
          if (r_hold <= 8'd1) begin
            w_state_nxt = c_ARM;
            w_hold_nxt  = 8'd0;
          end else begin
            w_hold_nxt  = r_hold - 8'd1;
          end
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_IDLE;
      r_hold  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  assign state          = r_state;
  assign capture_enable = (r_state == c_ARM);

  // --------------------------------------------------------------------------
  // Stage 1: read address and strobe
  // --------------------------------------------------------------------------
  // The read qualifier uses the next state, so the scan sample that carries
  // the frame start sees the same state the FSM moves into. The last frame
  // before re-arming therefore never reads a word while the filler is
  // writing, and the first displayed frame includes its column 0.
  logic [11:0] w_addr_full;
  logic        w_rd;
  logic        r_rd_en;
  logic [10:0] r_rd_addr;
  logic [9:0]  r_y1;

  assign w_addr_full = c_SKIP + 12'(CounterX) * c_DECIM;
  assign w_rd        = (w_state_nxt == c_DISPLAY) && inDisplayArea &&
                       ({1'b0, CounterX} < c_H_ACTIVE) && !w_addr_full[11];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_en   <= 1'b0;
      r_rd_addr <= 11'd0;
      r_y1      <= 10'd0;
    end else begin
      r_rd_en <= w_rd;
      r_y1    <= CounterY;
      if (w_rd) r_rd_addr <= w_addr_full[10:0];
    end
  end

  assign rd_en   = r_rd_en;
  assign rd_addr = r_rd_addr;

  // --------------------------------------------------------------------------
  // Stage 2: RAM data arrives; scan row and strobe are delayed to match it
  // --------------------------------------------------------------------------
  logic       r_en2;
  logic [9:0] r_y2;
  logic [9:0] w_row;
  logic       w_hit;
  logic       w_unused_lsbs;

  // Inverting the 8-bit code computes 255 - code, so high voltage is drawn
  // near the top of the trace window.
  assign w_row         = c_Y_OFFSET + {2'b00, ~ram_q[13:6]};
  assign w_unused_lsbs = &{1'b0, ram_q[5:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en2 <= 1'b0;
      r_y2  <= 10'd0;
    end else begin
      r_en2 <= r_rd_en;
      r_y2  <= r_y1;
    end
  end

`ifdef TRACE_FILL_EN
  logic       r_col0_1;
  logic       r_col0_2;
  logic [9:0] r_prev_row;
  logic [9:0] w_prev_eff;
  logic [9:0] w_lo;
  logic [9:0] w_hi;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col0_1   <= 1'b0;
      r_col0_2   <= 1'b0;
      r_prev_row <= 10'd0;
    end else begin
      r_col0_1 <= (CounterX == 10'd0);
      r_col0_2 <= r_col0_1;
      if (r_en2) r_prev_row <= w_row;
    end
  end

  // The first column of a line starts its own run. Without this, the line
  // would connect to the last sample of the previous line.
  assign w_prev_eff = r_col0_2 ? w_row : r_prev_row;
  assign w_lo       = (w_prev_eff < w_row) ? w_prev_eff : w_row;
  assign w_hi       = (w_prev_eff < w_row) ? w_row : w_prev_eff;
  assign w_hit      = (r_y2 >= w_lo) && (r_y2 <= w_hi);
`else
  assign w_hit      = (r_y2 == w_row);
`endif

  // --------------------------------------------------------------------------
  // Stage 3: pixel output
  // --------------------------------------------------------------------------
  logic r_pixel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_pixel <= 1'b0;
    else        r_pixel <= r_en2 && w_hit;
  end

  assign pixel_on = r_pixel;

endmodule
`default_nettype wire
